// File: rtl/edge_event_logger_pkg.sv
// Shared types and helpers for the edge event logger: event kind codes,
// the parameterized event record macro and the saturating counter step.

// Event record {kind, ts}; width-parameterized so the logger can size it.
`define EDGE_EVENT_T(W) struct packed { logic kind; logic [(W)-1:0] ts; }

package edge_log_pkg;

  localparam logic KIND_RISE = 1'b1;
  localparam logic KIND_FALL = 1'b0;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // Increment that sticks at the top value instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/edge_event_logger_if.sv
// Event stream from the logger FIFO head to the status/CSR reader.

interface edge_event_logger_if #(
  parameter int TS_WIDTH = 8
);

  logic                EV_VALID;
  logic                EV_READY;
  logic                EV_KIND;
  logic [TS_WIDTH-1:0] EV_TS;

  modport master (
    output EV_VALID,
    output EV_KIND,
    output EV_TS,
    input  EV_READY
  );

  modport slave (
    input  EV_VALID,
    input  EV_KIND,
    input  EV_TS,
    output EV_READY
  );

endinterface

// File: rtl/edge_event_logger_sync.sv
// Two-flop synchronizer for the asynchronous XIN pin plus a history flop
// used to turn the synchronized level into single-cycle rise/fall pulses.

module edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic XIN,
  output logic RISE,
  output logic FALL
);

  logic s1;
  logic s2;
  logic s3;

  // Sync chain; cleared on reset so XIN held high across release shows one rise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= XIN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign RISE = s2 & ~s3;
  assign FALL = ~s2 & s3;

endmodule

// File: rtl/edge_event_logger.sv
// Edge event logger: counts synchronized rise/fall edges of XIN in
// saturating counters and queues timestamped events for a downstream reader.

module edge_event_logger
  import edge_log_pkg::*;
#(
  parameter int TS_WIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                XIN,
  input  logic                CLR,
  output logic [CNT_W-1:0]    RISE_CNT,
  output logic [CNT_W-1:0]    FALL_CNT,
  output logic                OVERFLOW,
  edge_event_logger_if.master ev
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   occ_t;
  typedef `EDGE_EVENT_T(TS_WIDTH) event_t;

  localparam occ_t OCC_FULL = occ_t'(DEPTH);

  logic                rise;
  logic                fall;
  logic                edge_det;
  logic [TS_WIDTH-1:0] ts;
  cnt_t                rise_cnt;
  cnt_t                fall_cnt;
  logic                overflow;

  event_t              mem [DEPTH];
  ptr_t                wr_ptr;
  ptr_t                rd_ptr;
  occ_t                count;
  logic                ev_valid;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;
  event_t              new_ev;
  event_t              head;

  edge_sync u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .XIN   (XIN),
    .RISE  (rise),
    .FALL  (fall)
  );

  assign edge_det = rise | fall;
  assign ev_valid = (count != '0);
  assign full     = (count == OCC_FULL);
  assign pop      = ev_valid & ev.EV_READY;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = edge_det & ~CLR & (~full | pop);
  assign drop     = edge_det & ~CLR & full & ~pop;

  assign new_ev.kind = rise ? KIND_RISE : KIND_FALL;
  assign new_ev.ts   = ts;

  // Free-running timestamp; the soft clear deliberately leaves it alone.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // Saturating edge counters; an edge coinciding with CLR is not counted.
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      if (rise) rise_cnt <= sat_inc(rise_cnt);
      if (fall) fall_cnt <= sat_inc(fall_cnt);
    end
  end

  // Sticky overflow: an event was lost because no slot was available.
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // FIFO control: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + occ_t'(1);
        2'b01:   count <= count - occ_t'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage holds data only; validity comes from count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= new_ev;
    end
  end

  assign head = mem[rd_ptr];

  // Head fields are forced to 0 when empty so nothing uninitialized escapes.
  assign ev.EV_VALID = ev_valid;
  assign ev.EV_KIND  = ev_valid ? head.kind : 1'b0;
  assign ev.EV_TS    = ev_valid ? head.ts   : '0;

  assign RISE_CNT = rise_cnt;
  assign FALL_CNT = fall_cnt;
  assign OVERFLOW = overflow;

endmodule
